// File: rtl/mux_pkg.sv
// ============================================================================
// mux_pkg : shared widths, flit type codes and enable levels for the mux
// Revision 1.0
// ============================================================================
`default_nettype none

package mux_pkg;

  localparam int DATAW = 66;
  localparam int VCHW  = 2;
  localparam int PORTW = 5;

  // Flit type lives in the top two bits of a flit; the mux never decodes it.
  typedef enum logic [1:0] {
    TYPE_NONE = 2'b00,
    TYPE_HEAD = 2'b01,
    TYPE_DATA = 2'b10,
    TYPE_TAIL = 2'b11
  } flit_type_e;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  function automatic logic [DATAW-1:0] make_flit(input flit_type_e ftype,
                                                 input logic [63:0] payload);
    return {ftype, payload};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_oreg.sv
// ============================================================================
// mux_oreg : output register stage; valid always loads, data/vch on load enable
// Revision 1.0
// ============================================================================
`default_nettype none

module mux_oreg
  import mux_pkg::*;
#(
  parameter int DATAW = mux_pkg::DATAW,
  parameter int VCHW  = mux_pkg::VCHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             valid_d,
  input  logic [DATAW-1:0] data_d,
  input  logic [VCHW-1:0]  vch_d,
  output logic             valid_q,
  output logic [DATAW-1:0] data_q,
  output logic [VCHW-1:0]  vch_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= DISABLE;
      data_q  <= '0;
      vch_q   <= '0;
    end else begin
      valid_q <= valid_d;
      // Data and VC hold when nothing valid is selected to limit output toggling.
      if (load == ENABLE) begin
        data_q <= data_d;
        vch_q  <= vch_d;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux.sv
// ============================================================================
// mux : two-port flit select with priority to port 0 and one registered stage
// Revision 1.0
// ============================================================================
`default_nettype none

module mux
  import mux_pkg::*;
#(
  parameter int DATAW = mux_pkg::DATAW,
  parameter int VCHW  = mux_pkg::VCHW,
  parameter int PORTW = mux_pkg::PORTW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DATAW-1:0] idata_0,
  input  logic             ivalid_0,
  input  logic [VCHW-1:0]  ivch_0,
  input  logic [DATAW-1:0] idata_1,
  input  logic             ivalid_1,
  input  logic [VCHW-1:0]  ivch_1,
  input  logic [PORTW-1:0] sel,
  output logic [DATAW-1:0] odata,
  output logic             ovalid,
  output logic [VCHW-1:0]  ovch
);

  logic             sel_valid;
  logic [DATAW-1:0] sel_data;
  logic [VCHW-1:0]  sel_vch;
  logic             sel_load;

  // Select bits above port 1 belong to other router ports and are ignored here.
  logic unused_sel;
  assign unused_sel = ^sel[PORTW-1:2];

  always_comb begin
    sel_valid = DISABLE;
    sel_data  = idata_0;
    sel_vch   = ivch_0;
    if (sel[0]) begin
      sel_valid = ivalid_0;
      sel_data  = idata_0;
      sel_vch   = ivch_0;
    end else if (sel[1]) begin
      sel_valid = ivalid_1;
      sel_data  = idata_1;
      sel_vch   = ivch_1;
    end
    sel_load = sel_valid;
  end

  mux_oreg #(
    .DATAW (DATAW),
    .VCHW  (VCHW)
  ) u_oreg (
    .clk     (clk),
    .rst     (rst),
    .load    (sel_load),
    .valid_d (sel_valid),
    .data_d  (sel_data),
    .vch_d   (sel_vch),
    .valid_q (ovalid),
    .data_q  (odata),
    .vch_q   (ovch)
  );

endmodule

`default_nettype wire

// File: tb/tb_mux.sv
// ============================================================================
// tb_mux : directed vectors with a scoreboard queue and a decoupled monitor
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [65:0] idata_0, idata_1, odata;
  logic        ivalid_0, ivalid_1, ovalid;
  logic [1:0]  ivch_0, ivch_1, ovch;
  logic [4:0]  sel;

  typedef struct packed {
    logic        v;
    logic [65:0] d;
    logic [1:0]  c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mux dut (
    .clk      (clk),
    .rst      (rst),
    .idata_0  (idata_0),
    .ivalid_0 (ivalid_0),
    .ivch_0   (ivch_0),
    .idata_1  (idata_1),
    .ivalid_1 (ivalid_1),
    .ivch_1   (ivch_1),
    .sel      (sel),
    .odata    (odata),
    .ovalid   (ovalid),
    .ovch     (ovch)
  );

  always #5 clk = ~clk;

  function automatic logic [65:0] flit(input logic [1:0] t, input logic [63:0] p);
    return {t, p};
  endfunction

  // Drive one cycle of inputs and record what the outputs must show after the edge.
  task automatic step(input logic r, input logic [4:0] s,
                      input logic v0, input logic [65:0] d0, input logic [1:0] c0,
                      input logic v1, input logic [65:0] d1, input logic [1:0] c1,
                      input logic ev, input logic [65:0] ed, input logic [1:0] ec);
    exp_t e;
    @(negedge clk);
    rst = r; sel = s;
    ivalid_0 = v0; idata_0 = d0; ivch_0 = c0;
    ivalid_1 = v1; idata_1 = d1; ivch_1 = c1;
    e.v = ev; e.d = ed; e.c = ec;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    int   n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (ovalid !== e.v || odata !== e.d || ovch !== e.c) begin
          errors++;
          $display("FAIL out[%0d]: got v=%0b d=%h c=%0d, expected v=%0b d=%h c=%0d",
                   n, ovalid, odata, ovch, e.v, e.d, e.c);
        end
        n++;
      end
    end
  end

  initial begin : stimulus
    logic [65:0] head4, tail, f, junk, h9, fa, fb, fc;
    int          wait_cycles;
    head4 = flit(2'b01, 64'h4);
    tail  = flit(2'b11, 64'hDEAD_0000_0000_00FF);
    junk  = flit(2'b10, 64'h5555_AAAA_5555_AAAA);
    h9    = flit(2'b01, 64'h9);
    fa    = flit(2'b10, 64'hA0);
    fb    = flit(2'b10, 64'hB0);
    fc    = flit(2'b11, 64'hC0C0);

    rst = 1'b1; sel = '0;
    ivalid_0 = 1'b0; idata_0 = '0; ivch_0 = '0;
    ivalid_1 = 1'b0; idata_1 = '0; ivch_1 = '0;

    // Reset with both ports valid and both selected.
    step(1, 5'b00011, 1, junk, 2'd3, 1, fb, 2'd2, 0, 66'h0, 2'd0);
    step(1, 5'b00011, 1, junk, 2'd3, 1, fb, 2'd2, 0, 66'h0, 2'd0);

    // Port-1 packet while port 0 carries unrelated traffic.
    step(0, 5'b00010, 1, junk, 2'd3, 1, head4, 2'd2, 1, head4, 2'd2);
    for (int i = 0; i < 20; i++) begin
      f = flit(2'b10, 64'h1000 + 64'(i));
      step(0, 5'b00010, (i % 2) == 0, junk ^ 66'(i), 2'(i), 1, f, 2'd2, 1, f, 2'd2);
    end
    step(0, 5'b00010, 1, junk, 2'd1, 1, tail, 2'd2, 1, tail, 2'd2);

    // Selected valid drops: outputs hold the tail.
    step(0, 5'b00010, 1, junk, 2'd1, 0, fa, 2'd0, 0, tail, 2'd2);

    // Both selected: port 0 wins.
    step(0, 5'b00011, 1, h9, 2'd1, 1, fb, 2'd3, 1, h9, 2'd1);

    // No selection, including upper select bits only.
    step(0, 5'b00000, 1, fa, 2'd2, 1, fb, 2'd3, 0, h9, 2'd1);
    step(0, 5'b00000, 1, fa, 2'd2, 1, fb, 2'd3, 0, h9, 2'd1);
    step(0, 5'b11100, 1, fa, 2'd2, 1, fb, 2'd3, 0, h9, 2'd1);

    // Port 0 selected but idle while port 1 is valid.
    step(0, 5'b00001, 0, fc, 2'd2, 1, fb, 2'd3, 0, h9, 2'd1);

    // Switch from port 0 to port 1 between consecutive valid flits.
    step(0, 5'b00001, 1, fa, 2'd0, 1, junk, 2'd1, 1, fa, 2'd0);
    step(0, 5'b00010, 1, junk, 2'd1, 1, fb, 2'd3, 1, fb, 2'd3);

    // Reset beats a valid selected flit, then forwarding resumes at once.
    step(1, 5'b00001, 1, fc, 2'd1, 0, junk, 2'd0, 0, 66'h0, 2'd0);
    step(0, 5'b00001, 1, fc, 2'd1, 0, junk, 2'd0, 1, fc, 2'd1);
    step(0, 5'b00000, 0, junk, 2'd0, 0, junk, 2'd0, 0, fc, 2'd1);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs never observed, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
